sha_msg_sched_seq: RTL and testbench
====================================

# sha_msg_sched_seq

Sequential, parametrised SHA message scheduler. Accepts one 512/1024-bit padded message block and streams the round words W_0..W_{ROUNDS-1}, one per handshake, using a 16-word sliding window instead of materialising all round words at once. It supports SHA-1, SHA-256 and SHA-512 recurrences, and sits between the padding/block buffer and the round compression core.

## Interface
- WORD_W, 32: word width; 32 (SHA-1/SHA-256) or 64 (SHA-512).
- SHA2, 1: 0 selects the SHA-1 recurrence (WORD_W must be 32), 1 selects SHA-2.
- ROUNDS, derived: 80 for SHA-1 and SHA-512, 64 for SHA-256; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- blk_valid  in  1  block offered.
- blk_ready  out  1  block accepted when high with blk_valid.
- blk_data  in  16*WORD_W  block; big-endian, W_0 in the top word.
- w_valid  out  1  round word available.
- w_ready  in  1  consumer takes word.
- w_data  out  WORD_W  current round word W_t.
- w_idx  out  7  current t, 0..ROUNDS-1.
- w_last  out  1  high when w_idx == ROUNDS-1.
- abort  in  1  present only with SHA_SCHED_ABORT_EN.

## Operation
- FSM with two states:
  - IDLE: blk_ready=1, w_valid=0.
  - RUN: blk_ready=0, w_valid=1.
- Reset values: state IDLE, window all zero, idx 0. Outputs: blk_ready=1, w_valid=0, w_data=0, w_idx=0, w_last=0.
- IDLE, blk_valid&&blk_ready: load window[i] = blk_data[(16-i)*WORD_W-1 -: WORD_W] for i=0..15, set idx=0, go to RUN.
- RUN: w_data = window[0], w_idx = idx.
- RUN, w_valid&&w_ready:
  - Shift window down one slot.
  - window[15] <= next word.
  - idx <= idx+1.
  - If w_last, go to IDLE instead, with idx cleared.
- RUN, no handshake: all state holds, and w_data/w_idx stay stable (AXI-style; w_valid never drops before a handshake).
- Next word (computed from the current window):
  - SHA-1: rotl1(window[13]^window[8]^window[2]^window[0]).
  - SHA-2: σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^WORD_W, carries discarded.
- σ functions:
  - WORD_W=32: σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: σ0 = ROTR1^ROTR8^SHR7; σ1 = ROTR19^ROTR61^SHR6.
- Words computed for t ≥ ROUNDS are never presented; computing them in the last 16 rounds is harmless.
- blk_valid while in RUN is ignored and not consumed.
- Mid-operation reset: rst_n low immediately forces reset values; any partial block is discarded.

## Timing
- Block accepted at edge N: w_valid=1 with W_0 after edge N.
- With w_ready held high: one word per cycle, W_t visible in cycle N+1+t.
- Last handshake at edge M: blk_ready=1 from M onward. The next block can be accepted at edge M+1.
- Sustained throughput: ROUNDS+1 cycles per block.
- All outputs are registered or pure decodes of the state/window registers. There is no combinational path from w_ready or blk_valid to any output.

## Configuration
- SHA_SCHED_ABORT_EN defined: `abort` port exists.
  - abort=1 at a clock edge forces IDLE, idx=0 and a cleared window. This takes priority over any handshake in the same cycle; a simultaneous blk_valid is not accepted.
  - w_valid=0 and blk_ready=1 from the following cycle.
- Not defined: no port and no abort logic. The block runs every accepted block to completion.

## Structure
- Package sha_sched_pkg holds:
  - the state enum (IDLE, RUN);
  - functions rotr/shr, sig0_256/sig1_256, sig0_512/sig1_512;
  - function rounds(sha2, word_w);
  - the index width constant (7).
- One combinational sub-module, sha_sched_next_word (parameters WORD_W, SHA2): takes the four window taps and returns the next word. The top module holds the FSM, the window register and the counter.

## Test plan
- SHA-1, "abc" padded block (W_0=0x61626380, W_15=0x00000018), w_ready=1 → W_16=0xC2C4C700; 80 words; w_last only at idx 79; blk_ready returns the cycle after.
- SHA-256, "abc" block → W_16=0x61626380, W_17=0x000F0000; 64 words; w_last at idx 63.
- SHA-512, "abc" block (WORD_W=64) → all 80 words match the software model; W_16=0x6162638000000000.
- Random w_ready backpressure (50%) → w_data/w_idx stable while stalled; word sequence identical to the no-stall run.
- Back-to-back blocks with blk_valid held high → second block accepted exactly one cycle after the last handshake of the first; blk_valid during RUN is not consumed.
- Reset asserted at idx 37, and (with SHA_SCHED_ABORT_EN) abort asserted at idx 20 together with blk_valid → IDLE next cycle; w_valid=0; the new block is not accepted in the abort cycle.

Source files
------------

// File: rtl/sha_msg_sched_seq_pkg.sv
// Shared types and helpers for the sequential SHA message scheduler.
package sha_sched_pkg;

  typedef enum logic {IDLE, RUN} state_e;

  localparam int IDX_W = 7;

  // Rotate right within the low w bits of x (w = 32 or 64).
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (((x & m) >> n) | ((x & m) << (w - n))) & m;
  endfunction

  function automatic logic [63:0] shr(input logic [63:0] x, input int n);
    return x >> n;
  endfunction

  function automatic logic [31:0] sig0_256(input logic [31:0] x);
    logic [63:0] t;
    t = rotr({32'b0, x}, 7, 32) ^ rotr({32'b0, x}, 18, 32) ^ shr({32'b0, x}, 3);
    return t[31:0];
  endfunction

  function automatic logic [31:0] sig1_256(input logic [31:0] x);
    logic [63:0] t;
    t = rotr({32'b0, x}, 17, 32) ^ rotr({32'b0, x}, 19, 32) ^ shr({32'b0, x}, 10);
    return t[31:0];
  endfunction

  function automatic logic [63:0] sig0_512(input logic [63:0] x);
    return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ shr(x, 7);
  endfunction

  function automatic logic [63:0] sig1_512(input logic [63:0] x);
    return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ shr(x, 6);
  endfunction

  // SHA-256 runs 64 rounds; SHA-1 and SHA-512 run 80.
  function automatic int rounds(input int sha2, input int word_w);
    return (sha2 != 0 && word_w == 32) ? 64 : 80;
  endfunction

endpackage

// File: rtl/sha_msg_sched_seq_next_word.sv
// Combinational next-word recurrence for the 16-word sliding window.
// SHA-1: taps are w[0], w[2], w[8], w[13]; SHA-2: w[0], w[1], w[9], w[14].
module sha_sched_next_word
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SHA2   = 1
) (
  input  logic [WORD_W-1:0] tap0,
  input  logic [WORD_W-1:0] tap1,
  input  logic [WORD_W-1:0] tap2,
  input  logic [WORD_W-1:0] tap3,
  output logic [WORD_W-1:0] next_word
);

  generate
    if (SHA2 == 0) begin : g_sha1
      logic [WORD_W-1:0] x;
      assign x         = tap3 ^ tap2 ^ tap1 ^ tap0;
      assign next_word = {x[WORD_W-2:0], x[WORD_W-1]};
    end else if (WORD_W == 32) begin : g_sha256
      assign next_word = sig1_256(tap3) + tap2 + sig0_256(tap1) + tap0;
    end else begin : g_sha512
      assign next_word = sig1_512(tap3) + tap2 + sig0_512(tap1) + tap0;
    end
  endgenerate

endmodule

// File: rtl/sha_msg_sched_seq.sv
// Sequential SHA message scheduler: loads one padded block and streams
// W_0..W_{ROUNDS-1} over a valid/ready handshake from a 16-word window.
// Optional macro SHA_SCHED_ABORT_EN adds an `abort` input that drops the
// current block and returns to IDLE.
module sha_msg_sched_seq
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SHA2   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [IDX_W-1:0]     w_idx,
  output logic                 w_last
`ifdef SHA_SCHED_ABORT_EN
  ,
  input  logic                 abort
`endif
);

  localparam int               ROUNDS   = rounds(SHA2, WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  state_e                  state;
  logic [15:0][WORD_W-1:0] win;
  logic [IDX_W-1:0]        idx;
  logic [WORD_W-1:0]       nw;

  sha_sched_next_word #(.WORD_W(WORD_W), .SHA2(SHA2)) u_next (
    .tap0      (win[0]),
    .tap1      ((SHA2 != 0) ? win[1]  : win[2]),
    .tap2      ((SHA2 != 0) ? win[9]  : win[8]),
    .tap3      ((SHA2 != 0) ? win[14] : win[13]),
    .next_word (nw)
  );

  // Outputs are pure decodes of state/window/counter registers.
  assign blk_ready = (state == IDLE);
  assign w_valid   = (state == RUN);
  assign w_data    = (state == RUN) ? win[0] : '0;
  assign w_idx     = idx;
  assign w_last    = (state == RUN) && (idx == LAST_IDX);

  // Block load, window slide on each word handshake, return to IDLE after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      win   <= '0;
      idx   <= '0;
    end else begin
`ifdef SHA_SCHED_ABORT_EN
      if (abort) begin
        state <= IDLE;
        win   <= '0;
        idx   <= '0;
      end else begin
`else
      begin
`endif
        case (state)
          IDLE: if (blk_valid) begin
            for (int i = 0; i < 16; i++) win[i] <= blk_data[(16-i)*WORD_W-1 -: WORD_W];
            idx   <= '0;
            state <= RUN;
          end
          RUN: if (w_ready) begin
            win <= {nw, win[15:1]};
            if (w_last) begin
              state <= IDLE;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha_msg_sched_seq.sv
// Bench for sha_msg_sched_seq: three instances (SHA-1, SHA-256, SHA-512)
// checked against a full-expansion software model through a scoreboard.
module tb_sha_msg_sched_seq;

  typedef struct packed {
    logic [63:0] d;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  logic                   clk;
  logic                   rst_n;
  logic                   abort;
  logic [2:0]             bv, br, wv, wr, wl;
  logic [2:0][1023:0]     bd;
  logic [2:0][6:0]        wi;
  logic [31:0]            wd0, wd1;
  logic [63:0]            wd2;

  exp_t        sb[$];
  logic [63:0] got [80];
  int          ncmp;
  int          nerr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sha_msg_sched_seq #(.WORD_W(32), .SHA2(0)) u_sha1 (
    .clk(clk), .rst_n(rst_n), .blk_valid(bv[0]), .blk_ready(br[0]), .blk_data(bd[0][511:0]),
    .w_valid(wv[0]), .w_ready(wr[0]), .w_data(wd0), .w_idx(wi[0]), .w_last(wl[0])
`ifdef SHA_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  sha_msg_sched_seq #(.WORD_W(32), .SHA2(1)) u_sha256 (
    .clk(clk), .rst_n(rst_n), .blk_valid(bv[1]), .blk_ready(br[1]), .blk_data(bd[1][511:0]),
    .w_valid(wv[1]), .w_ready(wr[1]), .w_data(wd1), .w_idx(wi[1]), .w_last(wl[1])
`ifdef SHA_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  sha_msg_sched_seq #(.WORD_W(64), .SHA2(1)) u_sha512 (
    .clk(clk), .rst_n(rst_n), .blk_valid(bv[2]), .blk_ready(br[2]), .blk_data(bd[2]),
    .w_valid(wv[2]), .w_ready(wr[2]), .w_data(wd2), .w_idx(wi[2]), .w_last(wl[2])
`ifdef SHA_SCHED_ABORT_EN
    , .abort(abort)
`endif
  );

  function automatic logic [63:0] wdat(input int k);
    case (k)
      0:       return {32'b0, wd0};
      1:       return {32'b0, wd1};
      default: return wd2;
    endcase
  endfunction

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference: expand the whole block with the textbook W_t recurrence.
  function automatic void push_block(input int k, input logic [1023:0] blk);
    logic [63:0] w [80];
    logic [31:0] a, b, c, x;
    logic [63:0] p, q;
    int n;
    n = (k == 1) ? 64 : 80;
    for (int t = 0; t < 16; t++)
      w[t] = (k == 2) ? blk[1023-64*t -: 64] : {32'b0, blk[511-32*t -: 32]};
    for (int t = 16; t < 80; t++) begin
      if (k == 0) begin
        x    = w[t-3][31:0] ^ w[t-8][31:0] ^ w[t-14][31:0] ^ w[t-16][31:0];
        w[t] = {32'b0, x[30:0], x[31]};
      end else if (k == 1) begin
        a    = w[t-2][31:0];
        b    = w[t-15][31:0];
        c    = (r32(a, 17) ^ r32(a, 19) ^ (a >> 10)) + w[t-7][31:0]
             + (r32(b, 7) ^ r32(b, 18) ^ (b >> 3)) + w[t-16][31:0];
        w[t] = {32'b0, c};
      end else begin
        p    = w[t-2];
        q    = w[t-15];
        w[t] = (r64(p, 19) ^ r64(p, 61) ^ (p >> 6)) + w[t-7]
             + (r64(q, 1) ^ r64(q, 8) ^ (q >> 7)) + w[t-16];
      end
    end
    for (int t = 0; t < n; t++) sb.push_back('{d: w[t], idx: 7'(t), last: (t == n - 1)});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_blk_ready"}, br[k], 1);
      chk({tag, "_w_valid"}, wv[k], 0);
      chk({tag, "_w_data"}, wdat(k), 0);
      chk({tag, "_w_idx"}, wi[k], 0);
      chk({tag, "_w_last"}, wl[k], 0);
    end
  endtask

  // Called at a negedge; offers blk and returns at the negedge after acceptance.
  task automatic accept(input int k, input logic [1023:0] blk);
    bd[k] = blk;
    bv[k] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (br[k]) begin
        push_block(k, blk);
        @(negedge clk);
        bv[k] = 1'b0;
        chk("accept_w_valid", wv[k], 1);
        return;
      end
      @(negedge clk);
    end
    bv[k] = 1'b0;
    chk("accept_timeout", 0, 1);
  endtask

  // Consumes n words; every valid cycle is compared against the scoreboard head.
  task automatic stream(input int k, input int n, input int stall_pct);
    int   cnt;
    int   cyc;
    exp_t e;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < 3000) begin
      chk("w_valid", wv[k], 1);
      chk("blk_ready_run", br[k], 0);
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
        break;
      end
      e = sb[0];
      chk("w_data", wdat(k), e.d);
      chk("w_idx", wi[k], e.idx);
      chk("w_last", wl[k], e.last);
      wr[k] = ($urandom_range(99) >= stall_pct);
      if (wr[k]) begin
        got[e.idx] = wdat(k);
        void'(sb.pop_front());
        cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    wr[k] = 1'b0;
    if (cnt < n) chk("stream_timeout", cnt, n);
  endtask

  function automatic logic [1023:0] rand_blk();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] abc32, abc64, r1, r2;
    abc32 = {512'b0, 32'h61626380, 448'b0, 32'h18};
    abc64 = {64'h6162638000000000, 896'b0, 64'h18};
    ncmp  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    abort = 1'b0;
    bv    = '0;
    wr    = '0;
    bd    = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // SHA-1 "abc"
    accept(0, abc32);
    stream(0, 80, 0);
    chk("sha1_w0", got[0], 64'h61626380);
    chk("sha1_w15", got[15], 64'h18);
    chk("sha1_w16", got[16], 64'hC2C4C700);
    chk("sha1_done_ready", br[0], 1);
    chk("sha1_done_valid", wv[0], 0);

    // SHA-256 "abc"
    accept(1, abc32);
    stream(1, 64, 0);
    chk("sha256_w16", got[16], 64'h61626380);
    chk("sha256_w17", got[17], 64'h000F0000);
    chk("sha256_done_ready", br[1], 1);

    // SHA-512 "abc"
    accept(2, abc64);
    stream(2, 80, 0);
    chk("sha512_w16", got[16], 64'h6162638000000000);
    chk("sha512_done_ready", br[2], 1);

    // Backpressure on SHA-256 with a random block
    accept(1, rand_blk());
    stream(1, 64, 50);
    chk("stall_done_ready", br[1], 1);

    // Back-to-back on SHA-1: second block offered throughout the first
    r1 = rand_blk();
    r2 = rand_blk();
    accept(0, r1);
    bd[0] = r2;
    bv[0] = 1'b1;
    stream(0, 80, 0);
    chk("b2b_ready_after_last", br[0], 1);
    accept(0, r2);
    stream(0, 80, 30);

    // Reset mid-block at idx 37 on SHA-512
    accept(2, rand_blk());
    stream(2, 37, 0);
    chk("pre_reset_idx", wi[2], 37);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_ready", br[2], 1);
    chk("post_reset_valid", wv[2], 0);
    accept(2, rand_blk());
    stream(2, 80, 20);

`ifdef SHA_SCHED_ABORT_EN
    // Abort at idx 20 on SHA-256 with a new block offered in the same cycle
    accept(1, rand_blk());
    stream(1, 20, 0);
    chk("pre_abort_idx", wi[1], 20);
    r1    = rand_blk();
    abort = 1'b1;
    bd[1] = r1;
    bv[1] = 1'b1;
    wr[1] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wr[1] = 1'b0;
    chk("abort_w_valid", wv[1], 0);
    chk("abort_blk_ready", br[1], 1);
    chk("abort_w_idx", wi[1], 0);
    sb.delete();
    accept(1, r1);
    stream(1, 64, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
